// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges the ALU (A) and load (B) write streams onto the single
// regfile write port. Queued entries retire oldest-first using per-entry age stamps.

module wb_wr_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int SEQ_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [SEQ_W-1:0]  push_seq,
    input  logic              pop,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              full,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [SEQ_W-1:0]  head_seq,
    output logic              q_hit
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [SEQ_W-1:0]  seq_q  [DEPTH];
    logic [SEQ_W-1:0]  seq_d  [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Per-entry valid bits mirror the occupancy count so the hazard query can scan slots directly.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        seq_d    = seq_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                addr_d[wr_ptr_q]  = push_addr;
                data_d[wr_ptr_q]  = push_data;
                seq_d[wr_ptr_q]   = push_seq;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                seq_q[i]  <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            seq_q    <= seq_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == q_addr)) begin
                q_hit = 1'b1;
            end
        end
    end

    assign full       = (count_q == FULL_CNT);
    assign head_valid = (count_q != '0);
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign head_seq   = seq_q[rd_ptr_q];

endmodule

module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2,
    parameter int SEQ_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              flush,
    output logic              w_req,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_pending
);
    logic              a_full, b_full;
    logic              a_push, b_push;
    logic              a_head_valid, b_head_valid;
    logic [ADDR_W-1:0] a_head_addr, b_head_addr;
    logic [DATA_W-1:0] a_head_data, b_head_data;
    logic [SEQ_W-1:0]  a_head_seq, b_head_seq;
    logic              a_hit, b_hit;
    logic              grant_a, grant_b;
    logic [SEQ_W-1:0]  age_diff;
    logic [SEQ_W-1:0]  a_stamp, b_stamp;

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              w_req_q, w_req_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;

    // Writes to x0 complete the handshake but are dropped before they reach a FIFO.
    assign a_ready = rst & ~flush & ~a_full;
    assign b_ready = rst & ~flush & ~b_full;
    assign a_push  = a_valid & a_ready & (a_addr != '0);
    assign b_push  = b_valid & b_ready & (b_addr != '0);

    // A same-edge A store is older than B, so B takes the next stamp.
    assign a_stamp = seq_q;
    assign b_stamp = seq_q + SEQ_W'(a_push);

    wb_wr_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_fifo_a (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (a_push),
        .push_addr  (a_addr),
        .push_data  (a_data),
        .push_seq   (a_stamp),
        .pop        (grant_a),
        .q_addr     (q_addr),
        .full       (a_full),
        .head_valid (a_head_valid),
        .head_addr  (a_head_addr),
        .head_data  (a_head_data),
        .head_seq   (a_head_seq),
        .q_hit      (a_hit)
    );

    wb_wr_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) u_fifo_b (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (b_push),
        .push_addr  (b_addr),
        .push_data  (b_data),
        .push_seq   (b_stamp),
        .pop        (grant_b),
        .q_addr     (q_addr),
        .full       (b_full),
        .head_valid (b_head_valid),
        .head_addr  (b_head_addr),
        .head_data  (b_head_data),
        .head_seq   (b_head_seq),
        .q_hit      (b_hit)
    );

    // Stamps are compared modulo 2^SEQ_W: A is older when B is less than half the ring ahead.
    assign age_diff = b_head_seq - a_head_seq;
    assign grant_a  = ~flush & a_head_valid & (~b_head_valid | ~age_diff[SEQ_W-1]);
    assign grant_b  = ~flush & b_head_valid & ~grant_a;

    always_comb begin
        seq_d    = seq_q + SEQ_W'(a_push) + SEQ_W'(b_push);
        w_req_d  = grant_a | grant_b;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (grant_a) begin
            w_addr_d = a_head_addr;
            w_data_d = a_head_data;
        end else if (grant_b) begin
            w_addr_d = b_head_addr;
            w_data_d = b_head_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q    <= '0;
            w_req_q  <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            seq_q    <= seq_d;
            w_req_q  <= w_req_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    assign w_req     = w_req_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign q_pending = (q_addr != '0) & (a_hit | b_hit);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, single write, ordering, backpressure,
// zero register, flush, stamp wrap and asynchronous reset mid-stream.

module tb_wb_write_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        flush;
    logic        w_req;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  q_addr;
    logic        q_pending;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .SEQ_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .flush     (flush),
        .w_req     (w_req),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .q_addr    (q_addr),
        .q_pending (q_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input logic fl);
        a_valid = av;
        a_addr  = aa;
        a_data  = ad;
        b_valid = bv;
        b_addr  = ba;
        b_data  = bd;
        flush   = fl;
        #1;
    endtask

    task automatic setQuery(input logic [4:0] qa);
        q_addr = qa;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] pend_vec;
        int          k;
        int          exp_k;
        int          pat;

        rst     = 1'b0;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;
        flush   = 1'b0;
        q_addr  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_w_req", 32'(w_req), 32'd0);
        checkOutput("rst_w_addr", 32'(w_addr), 32'd0);
        checkOutput("rst_w_data", w_data, 32'd0);
        checkOutput("rst_a_ready", 32'(a_ready), 32'd0);
        checkOutput("rst_b_ready", 32'(b_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rel_a_ready", 32'(a_ready), 32'd1);
        checkOutput("rel_b_ready", 32'(b_ready), 32'd1);
        pend_vec = '0;
        for (int i = 0; i < 32; i++) begin
            setQuery(5'(i));
            pend_vec[i] = q_pending;
        end
        checkOutput("rel_q_pending_all", pend_vec, 32'd0);
        tick();

        // Single write from A
        $display("[TB] single write");
        setQuery(5'd5);
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("sw_a_ready", 32'(a_ready), 32'd1);
        checkOutput("sw_pend_before", 32'(q_pending), 32'd0);
        tick();
        idle();
        checkOutput("sw_pend_queued", 32'(q_pending), 32'd1);
        checkOutput("sw_w_req_early", 32'(w_req), 32'd0);
        tick();
        checkOutput("sw_w_req", 32'(w_req), 32'd1);
        checkOutput("sw_w_addr", 32'(w_addr), 32'd5);
        checkOutput("sw_w_data", w_data, 32'hDEADBEEF);
        checkOutput("sw_pend_after", 32'(q_pending), 32'd0);
        tick();
        checkOutput("sw_w_req_done", 32'(w_req), 32'd0);
        checkOutput("sw_w_addr_hold", 32'(w_addr), 32'd5);

        // Same-register ordering across both sources
        $display("[TB] ordering");
        setQuery(5'd3);
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0);
        checkOutput("ord_w_req0", 32'(w_req), 32'd0);
        checkOutput("ord_pend", 32'(q_pending), 32'd1);
        tick();
        idle();
        checkOutput("ord_w1_req", 32'(w_req), 32'd1);
        checkOutput("ord_w1_data", w_data, 32'h11);
        tick();
        checkOutput("ord_w2_req", 32'(w_req), 32'd1);
        checkOutput("ord_w2_data", w_data, 32'h22);
        tick();
        checkOutput("ord_w3_req", 32'(w_req), 32'd1);
        checkOutput("ord_w3_addr", 32'(w_addr), 32'd3);
        checkOutput("ord_w3_data", w_data, 32'h33);
        tick();
        checkOutput("ord_idle", 32'(w_req), 32'd0);
        checkOutput("ord_final_x3", w_data, 32'h33);
        checkOutput("ord_pend_clear", 32'(q_pending), 32'd0);

        // Zero-register write is accepted but never stored
        $display("[TB] zero register");
        setQuery(5'd0);
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("zr_a_ready", 32'(a_ready), 32'd1);
        checkOutput("zr_pend_pre", 32'(q_pending), 32'd0);
        tick();
        idle();
        checkOutput("zr_pend", 32'(q_pending), 32'd0);
        checkOutput("zr_w_req0", 32'(w_req), 32'd0);
        tick();
        checkOutput("zr_w_req1", 32'(w_req), 32'd0);
        tick();
        checkOutput("zr_w_req2", 32'(w_req), 32'd0);

        // Backpressure: B holds older entries while A fills
        $display("[TB] backpressure");
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h90, 1'b0);
        tick();
        checkOutput("bp_w_p0_addr", 32'(w_addr), 32'd7);
        checkOutput("bp_w_p0_data", w_data, 32'h70);
        applyStimulus(1'b1, 5'd12, 32'hA0, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("bp_b_full", 32'(b_ready), 32'd0);
        checkOutput("bp_a_ready_d3", 32'(a_ready), 32'd1);
        tick();
        checkOutput("bp_w_b0_data", w_data, 32'h80);
        applyStimulus(1'b1, 5'd13, 32'hA1, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("bp_a_ready_d4", 32'(a_ready), 32'd1);
        tick();
        checkOutput("bp_w_b1_data", w_data, 32'h90);
        applyStimulus(1'b1, 5'd14, 32'hA2, 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("bp_a_full", 32'(a_ready), 32'd0);
        tick();
        checkOutput("bp_w_a0_addr", 32'(w_addr), 32'd12);
        checkOutput("bp_w_a0_data", w_data, 32'hA0);
        checkOutput("bp_a_ready_d6", 32'(a_ready), 32'd1);
        tick();
        checkOutput("bp_w_a1_data", w_data, 32'hA1);
        applyStimulus(1'b1, 5'd15, 32'hA3, 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        idle();
        checkOutput("bp_w_a2_data", w_data, 32'hA2);
        tick();
        checkOutput("bp_w_a3_req", 32'(w_req), 32'd1);
        checkOutput("bp_w_a3_addr", 32'(w_addr), 32'd15);
        checkOutput("bp_w_a3_data", w_data, 32'hA3);
        tick();
        checkOutput("bp_idle", 32'(w_req), 32'd0);

        // Flush with entries queued in both FIFOs and a write in flight
        $display("[TB] flush");
        applyStimulus(1'b1, 5'd20, 32'hC0, 1'b1, 5'd22, 32'hC2, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd21, 32'hC1, 1'b1, 5'd23, 32'hC3, 1'b0);
        tick();
        idle();
        setQuery(5'd22);
        checkOutput("fl_pend_pre", 32'(q_pending), 32'd1);
        applyStimulus(1'b1, 5'd24, 32'hC4, 1'b0, 5'd0, 32'h0, 1'b1);
        checkOutput("fl_a_ready", 32'(a_ready), 32'd0);
        checkOutput("fl_b_ready", 32'(b_ready), 32'd0);
        checkOutput("fl_inflight_req", 32'(w_req), 32'd1);
        checkOutput("fl_inflight_addr", 32'(w_addr), 32'd20);
        tick();
        idle();
        checkOutput("fl_w_req", 32'(w_req), 32'd0);
        pend_vec = '0;
        for (int i = 20; i < 25; i++) begin
            setQuery(5'(i));
            pend_vec[i] = q_pending;
        end
        checkOutput("fl_pend_cleared", pend_vec, 32'd0);
        checkOutput("fl_a_ready_after", 32'(a_ready), 32'd1);
        tick();
        checkOutput("fl_w_req_after", 32'(w_req), 32'd0);

        // Twenty mixed writes; stamps wrap several times and must retire in push order
        $display("[TB] stamp wrap");
        k     = 0;
        exp_k = 0;
        for (int c = 0; c < 24; c++) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
            if (k < 20) begin
                pat = c % 4;
                if (pat == 0 || pat == 2) begin
                    a_valid = 1'b1;
                    a_addr  = 5'(k + 1);
                    a_data  = 32'h1000 + 32'(k);
                    k++;
                end
                if (pat == 0 || pat == 3) begin
                    b_valid = 1'b1;
                    b_addr  = 5'(k + 1);
                    b_data  = 32'h1000 + 32'(k);
                    k++;
                end
            end
            #1;
            tick();
            if (w_req) begin
                checkOutput("wrap_addr", 32'(w_addr), 32'(exp_k + 1));
                checkOutput("wrap_data", w_data, 32'h1000 + 32'(exp_k));
                exp_k++;
            end
        end
        idle();
        checkOutput("wrap_count", 32'(exp_k), 32'd20);

        // Asynchronous reset with a write in flight and an entry still queued
        $display("[TB] async reset");
        applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b0);
        tick();
        idle();
        tick();
        checkOutput("ar_w_req_pre", 32'(w_req), 32'd1);
        checkOutput("ar_w_addr_pre", 32'(w_addr), 32'd6);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_w_req", 32'(w_req), 32'd0);
        checkOutput("ar_w_addr", 32'(w_addr), 32'd0);
        checkOutput("ar_w_data", w_data, 32'd0);
        checkOutput("ar_a_ready", 32'(a_ready), 32'd0);
        checkOutput("ar_b_ready", 32'(b_ready), 32'd0);
        setQuery(5'd7);
        checkOutput("ar_pend", 32'(q_pending), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        checkOutput("ar_rel_a_ready", 32'(a_ready), 32'd1);
        checkOutput("ar_rel_w_req", 32'(w_req), 32'd0);
        checkOutput("ar_rel_pend", 32'(q_pending), 32'd0);
        tick();
        checkOutput("ar_lost_entry", 32'(w_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Merges two writeback streams onto the single regfile write port: an ALU/execute stream (port A) and a load/memory stream (port B). Each source has a small FIFO. Queued entries drain oldest-first so writes to the same register retire in program order. Outputs drive regfile w_req/w_addr/w_data directly. A combinational pending-write query lets decode stall on registers with queued, unretired writes.

Parameters:
DATA_W, 32, register data width (matches regfile RegBus)
ADDR_W, 5, register address width (matches regfile RegAddrBus)
DEPTH, 2, entries per source FIFO (power of 2, 2..4)
SEQ_W, 3, age-stamp width; must satisfy 2^SEQ_W >= 4*DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
a_valid  in  1  source A write request
a_ready  out  1  source A FIFO can accept
a_addr  in  ADDR_W  source A destination register
a_data  in  DATA_W  source A write data
b_valid  in  1  source B write request
b_ready  out  1  source B FIFO can accept
b_addr  in  ADDR_W  source B destination register
b_data  in  DATA_W  source B write data
flush  in  1  discard all queued entries
w_req  out  1  regfile write enable (registered)
w_addr  out  ADDR_W  regfile write address (registered)
w_data  out  DATA_W  regfile write data (registered)
q_addr  in  ADDR_W  hazard query address
q_pending  out  1  q_addr has a queued, unretired write

Behaviour:
- Reset (rst=0, async): both FIFOs empty, seq counter 0, w_req=0, w_addr=0, w_data=0. a_ready=b_ready=0 while rst=0 or flush=1; otherwise x_ready = !full_x.
- Accept: x_valid & x_ready at rising edge. Accepted entry with x_addr==0 completes handshake but is not stored and consumes no seq value.
- Age stamp: each stored entry gets current seq; seq advances by number of entries stored that edge (0/1/2, mod 2^SEQ_W). Simultaneous stores: A gets seq, B gets seq+1 (A is older).
- Arbitration (combinational, each cycle, flush=0): neither head valid -> no grant; one valid -> grant it; both -> grant older head, where A older iff ((seq_B - seq_A) mod 2^SEQ_W) < 2^(SEQ_W-1).
- Retire: at the edge, granted head popped; w_req<=1, w_addr/w_data<=head fields. No grant -> w_req<=0 (w_addr/w_data hold). At most one write per cycle.
- Latency: entry stored at edge E, FIFO otherwise empty -> w_req=1 during cycle following edge E+1. Steady-state throughput 1 write/cycle combined.
- Push and pop of same FIFO in one edge allowed; with FIFO full, ready stays 0 that cycle (ready not based on same-cycle pop).
- Pointers wrap mod DEPTH; occupancy counter 0..DEPTH distinguishes full/empty.
- q_pending = (q_addr!=0) & match against any valid stored entry in either FIFO. Output register excluded (regfile forwards during w_req cycle).
- flush=1 at edge: both FIFOs emptied, no grant, w_req<=0; same-cycle enqueues refused (ready=0). seq not reset. A write already on w_req in flush cycle still completes.
- Async reset mid-stream: all queued entries lost immediately; outputs 0 without waiting for clk.

Test Plan:
- Reset: rst=0 with FIFOs holding entries -> immediately w_req=0, w_addr=0, a_ready=b_ready=0; rst=1 -> ready=1 next cycle, q_pending=0 for all addresses.
- Single write: A writes (addr 5, 0xDEADBEEF), B idle -> w_req=1, w_addr=5, w_data=0xDEADBEEF one cycle after the following edge, q_pending(5)=1 until popped, then 0.
- Ordering: same edge A(3,0x11) and B(3,0x22), then B(3,0x33) -> w_req sequence 0x11,0x22,0x33 on consecutive cycles; final regfile x3=0x33.
- Backpressure: hold A valid 4 cycles while B keeps older entries queued (DEPTH=2) -> a_ready=0 when full, no A entry lost or duplicated; total 4 A writes retired in order.
- Zero register: A(0,0xFFFF_FFFF) accepted -> no w_req, q_pending(0)=0, seq unchanged.
- Flush: 2 entries queued per FIFO, flush=1 with a_valid=1 -> a_ready=0, FIFOs empty next cycle, w_req=0, q_pending=0; seq wrap exercised by 20 further mixed writes retiring in order.
